div_arbiter: RTL and testbench

- Shares one divider unit (7-bit divisor, 8-bit dividend, start/valid handshake) between NREQ independent requesters.
- Picks one requester per operation in round-robin order and latches its operands.
- Pulses start to the divider, waits for valid, then returns quotient/remainder to the winner with a one-cycle done pulse.
- Handles divide-by-zero without using the divider, and times out a hung divider.

---
 rtl/div_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_div_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one start/valid divider among NREQ requesters.
// Handles divide-by-zero locally and aborts an operation if the divider hangs.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31,
  parameter int PTRW    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [7*NREQ-1:0]   divisor_bus,
  input  logic [8*NREQ-1:0]   dividend_bus,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic [7:0]          quotient,
  output logic [6:0]          remainder,
  output logic                err,
  output logic                busy,
  output logic                div_start,
  output logic [6:0]          div_divisor,
  output logic [7:0]          div_dividend,
  input  logic [7:0]          div_quotient,
  input  logic [6:0]          div_remainder,
  input  logic                div_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = PTRW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        quot_q, quot_d;
  logic [6:0]        rem_q, rem_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [6:0]        dvsr_q, dvsr_d;
  logic [7:0]        dvnd_q, dvnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [PTRW-1:0]   win_s;
  logic              found_s;
  logic [SW-1:0]     cand_s;
  logic [NREQ-1:0]   onehot_s;
  logic [6:0]        dvsr_arr_s [NREQ];
  logic [7:0]        dvnd_arr_s [NREQ];
  logic [6:0]        sel_dvsr_s;
  logic [7:0]        sel_dvnd_s;

  // Round-robin search: first set request strictly after ptr_q, wrapping at NREQ.
  always_comb begin
    win_s   = ptr_q;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, ptr_q} + SW'(k);
      if (cand_s >= SW'(NREQ)) begin
        cand_s = cand_s - SW'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[PTRW-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[PTRW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    onehot_s = NREQ'(1'b1) << win_s;
  end

  // Operand unpacking and winner operand mux.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dvsr_arr_s[i] = divisor_bus[7*i +: 7];
      dvnd_arr_s[i] = dividend_bus[8*i +: 8];
    end
    sel_dvsr_s = dvsr_arr_s[win_s];
    sel_dvnd_s = dvnd_arr_s[win_s];
  end

  // Next-state logic; every output is registered from these _d values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    start_d = 1'b0;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          grant_d = onehot_s;
          ptr_d   = win_s;
          dvsr_d  = sel_dvsr_s;
          dvnd_d  = sel_dvnd_s;
          if (sel_dvsr_s == 7'd0) begin
            quot_d  = 8'hFF;
            rem_d   = 7'h00;
            err_d   = 1'b1;
            done_d  = onehot_s;
            state_d = S_RESP;
          end else begin
            start_d = 1'b1;
            state_d = S_START;
          end
        end else begin
          grant_d = '0;
        end
      end
      S_START: state_d = S_ARM;
      S_ARM: begin
        // div_valid deliberately ignored here to drop a stale valid.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_valid) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          err_d   = 1'b0;
          done_d  = grant_q;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          quot_d  = 8'hFF;
          rem_d   = 7'h7F;
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PTRW'(NREQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      quot_q  <= 8'h00;
      rem_q   <= 7'h00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      dvsr_q  <= 7'h00;
      dvnd_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign quotient     = quot_q;
  assign remainder    = rem_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign div_start    = start_q;
  assign div_divisor  = dvsr_q;
  assign div_dividend = dvnd_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider driven from the test tasks.
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [27:0] divisor_bus;
  logic [31:0] dividend_bus;
  logic [3:0]  grant, done;
  logic [7:0]  quotient;
  logic [6:0]  remainder;
  logic        err, busy, div_start;
  logic [6:0]  div_divisor;
  logic [7:0]  div_dividend;
  logic [7:0]  div_quotient;
  logic [6:0]  div_remainder;
  logic        div_valid;

  int n_checks = 0;
  int n_errors = 0;

  div_arbiter #(.NREQ(4), .TIMEOUT(31), .PTRW(2)) dut (
    .clk(clk), .reset(reset), .req(req),
    .divisor_bus(divisor_bus), .dividend_bus(dividend_bus),
    .grant(grant), .done(done), .quotient(quotient), .remainder(remainder),
    .err(err), .busy(busy), .div_start(div_start),
    .div_divisor(div_divisor), .div_dividend(div_dividend),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_valid(div_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [6:0] dv, input logic [7:0] dd);
    divisor_bus[7*i +: 7]  = dv;
    dividend_bus[8*i +: 8] = dd;
  endtask

  // Starts at a negedge with the DUT idle; cycle 0 is the next rising edge.
  task automatic run_op(input string tag, input logic [3:0] r, input int lat,
                        input bit hang, input bit stale, input bit drop,
                        input logic [3:0] exp_one, input logic [7:0] exp_q,
                        input logic [6:0] exp_r, input logic exp_e,
                        input int exp_cyc, input int exp_starts);
    int start_cyc, starts, done_cyc;
    logic [3:0] done_v, grant_v;
    logic busy_v, e_v;
    logic [7:0] q_v;
    logic [6:0] r_v;
    start_cyc = -1; starts = 0; done_cyc = -1;
    done_v = '0; grant_v = '0; busy_v = 1'b0; e_v = 1'b0; q_v = '0; r_v = '0;
    req = r;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        grant_v = grant;
        busy_v  = busy;
      end
      if (div_start) begin
        starts++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (done != 4'b0000) begin
        done_cyc = c; done_v = done; q_v = quotient; r_v = remainder; e_v = err;
        break;
      end
      if (!hang && start_cyc > 0 && c == start_cyc + lat) begin
        div_valid     = 1'b1;
        div_quotient  = div_dividend / {1'b0, div_divisor};
        div_remainder = 7'(div_dividend % {1'b0, div_divisor});
      end else if (!(stale && c <= 2)) begin
        div_valid = 1'b0;
      end
    end
    check($sformatf("%s.grant", tag), 32'(grant_v), 32'(exp_one));
    check($sformatf("%s.busy", tag), 32'(busy_v), 32'd1);
    check($sformatf("%s.done", tag), 32'(done_v), 32'(exp_one));
    check($sformatf("%s.quot", tag), 32'(q_v), 32'(exp_q));
    check($sformatf("%s.rem", tag), 32'(r_v), 32'(exp_r));
    check($sformatf("%s.err", tag), 32'(e_v), 32'(exp_e));
    check($sformatf("%s.done_cyc", tag), 32'(done_cyc), 32'(exp_cyc));
    check($sformatf("%s.starts", tag), 32'(starts), 32'(exp_starts));
    if (drop) req = req & ~done_v;
    @(posedge clk); @(negedge clk);
    check($sformatf("%s.done_after", tag), 32'(done), 32'd0);
    check($sformatf("%s.grant_after", tag), 32'(grant), 32'd0);
    check($sformatf("%s.busy_after", tag), 32'(busy), 32'd0);
    check($sformatf("%s.quot_hold", tag), 32'(quotient), 32'(exp_q));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req = 4'b0000; divisor_bus = '0; dividend_bus = '0;
    div_quotient = 8'h00; div_remainder = 7'h00; div_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.grant", 32'(grant), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.start", 32'(div_start), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.quot", 32'(quotient), 32'd0);
    check("rst.rem", 32'(remainder), 32'd0);
    check("rst.dvsr", 32'(div_divisor), 32'd0);
    check("rst.dvnd", 32'(div_dividend), 32'd0);
    reset = 1'b1;

    // Round robin with all requests held: 0,1,2,3,0.
    set_ops(0, 7'd9, 8'd200);
    set_ops(1, 7'd1, 8'd255);
    set_ops(2, 7'd7, 8'd100);
    set_ops(3, 7'd5, 8'd50);
    run_op("rr0", 4'b1111, 2, 1'b0, 1'b0, 1'b0, 4'b0001, 8'd22,  7'd2, 1'b0, 4, 1);
    run_op("rr1", 4'b1111, 2, 1'b0, 1'b0, 1'b0, 4'b0010, 8'd255, 7'd0, 1'b0, 4, 1);
    run_op("rr2", 4'b1111, 2, 1'b0, 1'b0, 1'b0, 4'b0100, 8'd14,  7'd2, 1'b0, 4, 1);
    run_op("rr3", 4'b1111, 2, 1'b0, 1'b0, 1'b0, 4'b1000, 8'd10,  7'd0, 1'b0, 4, 1);
    run_op("rr4", 4'b1111, 2, 1'b0, 1'b0, 1'b0, 4'b0001, 8'd22,  7'd2, 1'b0, 4, 1);
    req = 4'b0000;

    // Divide by zero never touches the divider.
    set_ops(2, 7'd0, 8'd57);
    run_op("dz", 4'b0100, 2, 1'b0, 1'b0, 1'b1, 4'b0100, 8'hFF, 7'h00, 1'b1, 1, 0);
    set_ops(2, 7'd7, 8'd100);

    // Hung divider: WAIT entered at cycle 3, done TIMEOUT+1 cycles later.
    run_op("tmo", 4'b0010, 2, 1'b1, 1'b0, 1'b1, 4'b0010, 8'hFF, 7'h7F, 1'b1, 35, 1);

    // Normal operation after the timeout.
    set_ops(0, 7'd7, 8'd100);
    run_op("single", 4'b0001, 9, 1'b0, 1'b0, 1'b1, 4'b0001, 8'd14, 7'd2, 1'b0, 11, 1);

    // Stale valid from the previous op stays high through START and ARM.
    set_ops(1, 7'd5, 8'd50);
    div_valid = 1'b1;
    run_op("stale", 4'b0010, 4, 1'b0, 1'b1, 1'b1, 4'b0010, 8'd10, 7'd0, 1'b0, 6, 1);

    // Reset asserted while waiting on the divider.
    div_valid = 1'b0;
    req = 4'b0100;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
    end
    check("mrst.pre_grant", 32'(grant), 32'b0100);
    check("mrst.pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    req   = 4'b0000;
    #1;
    check("mrst.grant", 32'(grant), 32'd0);
    check("mrst.done", 32'(done), 32'd0);
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.start", 32'(div_start), 32'd0);
    check("mrst.quot", 32'(quotient), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post", 4'b1000, 3, 1'b0, 1'b0, 1'b1, 4'b1000, 8'd10, 7'd0, 1'b0, 5, 1);

    // Pointer now at 3, so requester 0 beats requester 1.
    set_ops(0, 7'd9, 8'd200);
    run_op("wrap", 4'b0011, 2, 1'b0, 1'b0, 1'b1, 4'b0001, 8'd22, 7'd2, 1'b0, 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
